arqui_ctrl: RTL and testbench

Top-level control FSM for the arqui FIFO datapath (main FIFO, two VC FIFOs, two D FIFOs). Sequences reset, threshold configuration, idle and active operation, and error lock-out. Captures the almost-full/almost-empty thresholds during INIT and drives them to the FIFOs. Generates the `pause` backpressure to the main-FIFO producer and reports `idle`/`active`/`error` status.

---
 rtl/arqui_ctrl.sv | 140 ++++++++++++++
 tb/tb_arqui_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/arqui_ctrl.sv
// arqui_ctrl: top-level control FSM for the arqui FIFO datapath.
// Sequences RESET -> INIT -> IDLE/ACTIVE, locks out on FIFO errors, captures the
// FIFO thresholds during INIT and drives producer backpressure (pause).
// Optional feature macro: PAUSE_HYST_EN (pause with hysteresis on the main FIFO).
module arqui_ctrl #(
  parameter int unsigned MF_W = 2,
  parameter int unsigned VC_W = 4,
  parameter int unsigned DF_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init,
  input  logic [MF_W-1:0] afMF_i,
  input  logic [MF_W-1:0] aeMF_i,
  input  logic [VC_W-1:0] afVC_i,
  input  logic [VC_W-1:0] aeVC_i,
  input  logic [DF_W-1:0] afDF_i,
  input  logic [DF_W-1:0] aeDF_i,
  input  logic [4:0]      fifo_empty,
  input  logic [4:0]      fifo_almost_full,
  input  logic [4:0]      fifo_almost_empty,
  input  logic [4:0]      fifo_error,
  output logic [MF_W-1:0] afMF_o,
  output logic [MF_W-1:0] aeMF_o,
  output logic [VC_W-1:0] afVC_o,
  output logic [VC_W-1:0] aeVC_o,
  output logic [DF_W-1:0] afDF_o,
  output logic [DF_W-1:0] aeDF_o,
  output logic            pause,
  output logic            idle_out,
  output logic            active_out,
  output logic [4:0]      error_out,
  output logic [2:0]      state_out
);

  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StInit   = 3'd1,
    StIdle   = 3'd2,
    StActive = 3'd3,
    StError  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_run_next;
  logic            w_pause_d;
  logic            r_pause;
  logic [4:0]      r_error;
  logic [MF_W-1:0] r_afMF;
  logic [MF_W-1:0] r_aeMF;
  logic [VC_W-1:0] r_afVC;
  logic [VC_W-1:0] r_aeVC;
  logic [DF_W-1:0] r_afDF;
  logic [DF_W-1:0] r_aeDF;
  logic            w_unused;

  // Only the main-FIFO almost-empty flag matters, and only with hysteresis.
  assign w_unused = ^fifo_almost_empty;

  // Next-state decode; illegal encodings fall back to RESET.
  always_comb begin
    w_next = StReset;
    case (r_state)
      StReset: w_next = StInit;
      StInit:  w_next = init ? StInit : StIdle;
      StIdle, StActive: begin
        if (|fifo_error) begin
          w_next = StError;
        end else if (init) begin
          w_next = StInit;
        end else if (&fifo_empty) begin
          w_next = StIdle;
        end else begin
          w_next = StActive;
        end
      end
      StError: w_next = StError;
      default: w_next = StReset;
    endcase
  end

  // Backpressure next value, computed against the next state.
  always_comb begin
    w_run_next = (w_next == StIdle) || (w_next == StActive);
`ifdef PAUSE_HYST_EN
    w_pause_d = r_pause;
    if (!w_run_next || (|fifo_almost_full)) begin
      w_pause_d = 1'b1;
    end else if (fifo_almost_empty[0]) begin
      w_pause_d = 1'b0;
    end
`else
    w_pause_d = !w_run_next || (|fifo_almost_full);
`endif
  end

  // State, thresholds, sticky error record and pause registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StReset;
      r_pause <= 1'b1;
      r_error <= '0;
      r_afMF  <= '0;
      r_aeMF  <= '0;
      r_afVC  <= '0;
      r_aeVC  <= '0;
      r_afDF  <= '0;
      r_aeDF  <= '0;
    end else begin
      r_state <= w_next;
      r_pause <= w_pause_d;
      if (r_state == StInit) begin
        r_afMF <= afMF_i;
        r_aeMF <= aeMF_i;
        r_afVC <= afVC_i;
        r_aeVC <= aeVC_i;
        r_afDF <= afDF_i;
        r_aeDF <= aeDF_i;
      end
      // Errors are only recorded once configuration is done.
      if ((r_state == StIdle) || (r_state == StActive) || (r_state == StError)) begin
        r_error <= r_error | fifo_error;
      end
    end
  end

  assign afMF_o     = r_afMF;
  assign aeMF_o     = r_aeMF;
  assign afVC_o     = r_afVC;
  assign aeVC_o     = r_aeVC;
  assign afDF_o     = r_afDF;
  assign aeDF_o     = r_aeDF;
  assign pause      = r_pause;
  assign error_out  = r_error;
  assign state_out  = r_state;
  assign idle_out   = (r_state == StIdle);
  assign active_out = (r_state == StActive);

endmodule

// File: tb/tb_arqui_ctrl.sv
// Self-checking bench for arqui_ctrl: each scenario task drives one input set per
// cycle, queues the expected output vector, and compares queued observations.
module tb_arqui_ctrl;

  logic        clk;
  logic        reset;
  logic        init;
  logic [15:0] thr_in;
  logic [4:0]  fifo_empty;
  logic [4:0]  fifo_almost_full;
  logic [4:0]  fifo_almost_empty;
  logic [4:0]  fifo_error;
  logic [1:0]  afMF_o, aeMF_o, afDF_o, aeDF_o;
  logic [3:0]  afVC_o, aeVC_o;
  logic        pause, idle_out, active_out;
  logic [4:0]  error_out;
  logic [2:0]  state_out;
  logic [26:0] obs;

  int tests;
  int fails;

  logic [26:0] exp_q[$];
  logic [26:0] obs_q[$];

`ifdef PAUSE_HYST_EN
  localparam bit Hyst = 1'b1;
`else
  localparam bit Hyst = 1'b0;
`endif

  // Threshold sets packed as {afMF, aeMF, afVC, aeVC, afDF, aeDF}.
  localparam logic [15:0] T1 = {2'b11, 2'b01, 4'b1110, 4'b0011, 2'b01, 2'b10};
  localparam logic [15:0] T2 = {2'b01, 2'b10, 4'b0101, 4'b1010, 2'b10, 2'b01};
  localparam logic [15:0] T3 = {2'b10, 2'b11, 4'b1001, 4'b0110, 2'b11, 2'b00};

  arqui_ctrl #(
    .MF_W(2),
    .VC_W(4),
    .DF_W(2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .init              (init),
    .afMF_i            (thr_in[15:14]),
    .aeMF_i            (thr_in[13:12]),
    .afVC_i            (thr_in[11:8]),
    .aeVC_i            (thr_in[7:4]),
    .afDF_i            (thr_in[3:2]),
    .aeDF_i            (thr_in[1:0]),
    .fifo_empty        (fifo_empty),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_error        (fifo_error),
    .afMF_o            (afMF_o),
    .aeMF_o            (aeMF_o),
    .afVC_o            (afVC_o),
    .aeVC_o            (aeVC_o),
    .afDF_o            (afDF_o),
    .aeDF_o            (aeDF_o),
    .pause             (pause),
    .idle_out          (idle_out),
    .active_out        (active_out),
    .error_out         (error_out),
    .state_out         (state_out)
  );

  assign obs = {state_out, pause, idle_out, active_out, error_out,
                afMF_o, aeMF_o, afVC_o, aeVC_o, afDF_o, aeDF_o};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output vector; idle/active follow directly from the state code.
  function automatic logic [26:0] pk(input logic [2:0] st, input logic p,
                                     input logic [4:0] er, input logic [15:0] th);
    return {st, p, st == 3'd2, st == 3'd3, er, th};
  endfunction

  // Apply one cycle of stimulus, queue its expectation, capture the result after the edge.
  task automatic drive(input logic rst, input logic ini, input logic [4:0] emp,
                       input logic [4:0] af, input logic [4:0] ae, input logic [4:0] fer,
                       input logic [15:0] th, input logic [26:0] e);
    reset             = rst;
    init              = ini;
    fifo_empty        = emp;
    fifo_almost_full  = af;
    fifo_almost_empty = ae;
    fifo_error        = fer;
    thr_in            = th;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs_q.push_back(obs);
  endtask

  task automatic test_reset();
    logic [26:0] e, o;
    drive(1, 0, 5'h1F, 0, 5'h1F, 0, T1, pk(0, 1, 0, 0));
    drive(1, 0, 5'h1F, 0, 5'h1F, 0, T1, pk(0, 1, 0, 0));
    drive(0, 0, 5'h1F, 0, 5'h1F, 0, T1, pk(1, 1, 0, 0));
    drive(0, 0, 5'h1F, 0, 5'h1F, 0, T1, pk(2, 0, 0, T1));
    drive(0, 0, 5'h1F, 0, 5'h1F, 0, T1, pk(2, 0, 0, T1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_activity();
    logic [26:0] e, o;
    for (int k = 0; k < 3; k++) drive(0, 0, 5'h1E, 0, 5'h1F, 0, T1, pk(3, 0, 0, T1));
    drive(0, 0, 5'h1F, 0, 5'h1F, 0, T1, pk(2, 0, 0, T1));
    drive(0, 0, 5'h1F, 0, 5'h1F, 0, T1, pk(2, 0, 0, T1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL activity[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [26:0] e, o;
    drive(0, 0, 5'h1E, 0, 5'h1F, 0, T1, pk(3, 0, 0, T1));
    for (int k = 0; k < 4; k++) drive(0, 0, 5'h1E, 5'h02, 5'h00, 0, T1, pk(3, 1, 0, T1));
    // Almost-full gone but main FIFO not yet almost-empty: hysteresis keeps pause.
    for (int k = 0; k < 2; k++) drive(0, 0, 5'h1E, 0, 5'h00, 0, T1, pk(3, Hyst, 0, T1));
    drive(0, 0, 5'h1E, 0, 5'h1F, 0, T1, pk(3, 0, 0, T1));
    // Last pop together with almost-full: goes idle, pause still follows almost-full.
    drive(0, 0, 5'h1F, 5'h02, 5'h1F, 0, T1, pk(2, 1, 0, T1));
    drive(0, 0, 5'h1F, 0, 5'h1F, 0, T1, pk(2, 0, 0, T1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL backpressure[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_error();
    logic [26:0] e, o;
    drive(0, 0, 5'h1E, 0, 5'h1F, 0,     T1, pk(3, 0, 0,     T1));
    drive(0, 0, 5'h1E, 0, 5'h1F, 5'h08, T1, pk(4, 1, 5'h08, T1));
    drive(0, 0, 5'h1E, 0, 5'h1F, 0,     T1, pk(4, 1, 5'h08, T1));
    drive(0, 1, 5'h1E, 0, 5'h1F, 0,     T2, pk(4, 1, 5'h08, T1));
    drive(0, 0, 5'h1E, 0, 5'h1F, 5'h01, T2, pk(4, 1, 5'h09, T1));
    drive(0, 0, 5'h1F, 0, 5'h1F, 0,     T2, pk(4, 1, 5'h09, T1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL error[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_reconfig();
    logic [26:0] e, o;
    drive(1, 0, 5'h1F, 0, 5'h1F, 0,     T1, pk(0, 1, 0,     0));
    drive(0, 0, 5'h1F, 0, 5'h1F, 0,     T1, pk(1, 1, 0,     0));
    drive(0, 0, 5'h1F, 0, 5'h1F, 0,     T1, pk(2, 0, 0,     T1));
    // init and error together in IDLE: error wins.
    drive(0, 1, 5'h1F, 0, 5'h1F, 5'h04, T1, pk(4, 1, 5'h04, T1));
    drive(1, 0, 5'h1F, 0, 5'h1F, 0,     T1, pk(0, 1, 0,     0));
    drive(0, 0, 5'h1F, 0, 5'h1F, 0,     T1, pk(1, 1, 0,     0));
    drive(0, 0, 5'h1F, 0, 5'h1F, 0,     T1, pk(2, 0, 0,     T1));
    drive(0, 0, 5'h1E, 0, 5'h1F, 0,     T1, pk(3, 0, 0,     T1));
    drive(0, 1, 5'h1E, 0, 5'h1F, 0,     T2, pk(1, 1, 0,     T1));
    drive(0, 0, 5'h1E, 0, 5'h1F, 0,     T2, pk(2, 0, 0,     T2));
    drive(0, 0, 5'h1E, 0, 5'h1F, 0,     T2, pk(3, 0, 0,     T2));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL reconfig[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_init();
    logic [26:0] e, o;
    drive(0, 1, 5'h1E, 0, 5'h1F, 0, T3, pk(1, 1, 0, T2));
    drive(0, 1, 5'h1E, 0, 5'h1F, 0, T3, pk(1, 1, 0, T3));
    drive(0, 1, 5'h1E, 0, 5'h1F, 0, T1, pk(1, 1, 0, T1));
    drive(1, 1, 5'h1E, 0, 5'h1F, 0, T1, pk(0, 1, 0, 0));
    drive(0, 0, 5'h1F, 0, 5'h1F, 0, T1, pk(1, 1, 0, 0));
    drive(0, 0, 5'h1F, 0, 5'h1F, 0, T1, pk(2, 0, 0, T1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset_mid_init[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  initial begin
    tests             = 0;
    fails             = 0;
    reset             = 1'b1;
    init              = 1'b0;
    thr_in            = '0;
    fifo_empty        = 5'h1F;
    fifo_almost_full  = '0;
    fifo_almost_empty = 5'h1F;
    fifo_error        = '0;
    test_reset();
    test_activity();
    test_backpressure();
    test_error();
    test_reconfig();
    test_reset_mid_init();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
